lut_k_cfg: RTL
==============

Name: lut_k_cfg

Overview:
- Parametrised K-input lookup table: the successor of the fixed 4-input case-statement LUT.
- Truth table is held in a 2^K-bit configuration register that resets to INIT and can be reloaded at runtime through a serial shift chain with valid handshake.
- Output is optionally registered.
- Used as a configurable logic cell in diagram and test designs; multiple instances chain through cfg_out to form a configuration scan path.

Parameters:
- K, 4, number of LUT inputs (1..6); table size N = 2^K.
- INIT, 16'h9701, N-bit reset truth table; bit i is the output for I == i. The default equals the 4-input test LUT: ones at I = 0, 8, 9, 10, 12, 15.
- REG_OUT, 1, 1 = O registered (one-cycle latency); 0 = O combinational from the table.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I  input  K  LUT select inputs.
- O  output  1  LUT output.
- O_valid  output  1  high when O reflects a stable, fully loaded table.
- cfg_start  input  1  one-cycle pulse: begin a serial reload.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial configuration data, table bit 0 first.
- cfg_busy  output  1  high while in LOAD.
- cfg_done  output  1  one-cycle pulse when the Nth bit has been accepted.
- cfg_out  output  1  bit shifted out of the table (table[0] before the shift), for chaining.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - table = INIT, state = RUN, bit counter = 0.
  - cfg_busy = 0, cfg_done = 0, cfg_out = INIT[0], O_valid = 0 for one cycle after reset, then 1.
  - Registered O = 0; combinational O = INIT[I].
- RUN state:
  - REG_OUT=1: O <= table[I] each cycle; O follows a change on I one cycle later.
  - REG_OUT=0: O = table[I] combinationally.
  - O_valid = 1, except in the first cycle after reset or after leaving LOAD.
  - cfg_valid is ignored in RUN.
- RUN -> LOAD on cfg_start=1:
  - Counter cleared; cfg_busy = 1 from the next cycle.
  - If cfg_valid is also high in that cycle, the bit is ignored.
- LOAD state:
  - Each cycle with cfg_valid=1: table <= {cfg_bit, table[N-1:1]}; cfg_out <= table[0]; counter += 1.
  - After N accepted bits, the first bit presented sits in table[0].
  - Cycles with cfg_valid=0 hold all state; gaps are allowed.
  - O is frozen at its last RUN value; O_valid = 0.
- LOAD -> RUN: in the cycle the Nth bit is accepted, the counter reaches N-1 and table updates.
  - Next cycle: state = RUN, cfg_done = 1 for exactly one cycle, cfg_busy = 0.
  - Registered O shows the new table[I] in the cycle after that; O_valid rises with it.
- cfg_start while in LOAD restarts the load:
  - Counter cleared; bits already shifted stay in the table and are overwritten by the new N bits.
  - A cfg_valid in the same cycle is ignored.
- rst mid-load: table returns to INIT, state RUN, no cfg_done pulse.
- Counter width is K+1 bits and never wraps; excess cfg_valid after completion is ignored because the block is back in RUN.
- I is don't-care in LOAD.
- No X propagation: table is always fully defined.

Test Plan:
- Reset, K=4, INIT default, REG_OUT=1; sweep I = 0..15 one value per cycle -> O = 1 one cycle after I = 0, 8, 9, 10, 12, 15, else 0; O_valid = 1 from cycle 2.
- cfg_start, then 16 cfg_valid bits of 16'h0001 (LSB first) with one idle gap after bit 5 -> cfg_busy high for 17 cycles, cfg_done pulses once, then O = 1 only for I = 0. cfg_out sequence equals INIT bits 0..15 = 1,0,0,0,0,0,0,0,1,1,1,0,1,0,0,1.
- Load 16'hFFFF; assert rst after 7 bits -> next cycle cfg_busy = 0, no cfg_done; I = 3 gives O = 0 (INIT restored).
- Load 16'h8000; issue cfg_start again after 4 bits, then a full 16'h8000 -> exactly one cfg_done; O = 1 only for I = 15.
- K=2, INIT=4'b0110, REG_OUT=0 -> O = I[1]^I[0] combinationally with zero latency; load 4'b1000 -> AND behaviour.
- cfg_valid pulses in RUN with no cfg_start -> table unchanged, cfg_done never asserts.

Source files
------------

// File: rtl/lut_k_cfg.sv
// lut_k_cfg: K-input LUT with serially reloadable truth table; ports: clk, rst, I/O/O_valid lookup, cfg_start/cfg_valid/cfg_bit/cfg_busy/cfg_done/cfg_out reload chain
module lut_k_cfg #(
  parameter int K = 4,
  parameter logic [(1<<K)-1:0] INIT = 16'h9701,
  parameter bit REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] I,
  output logic         O,
  output logic         O_valid,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_busy,
  output logic         cfg_done,
  output logic         cfg_out
);
  localparam int N = 1 << K;
  localparam logic [K:0] LAST = (K+1)'(N - 1);
  typedef enum logic {RUN, LOAD} state_t;
  state_t state;
  logic [N-1:0] tbl;
  logic [K:0] cnt;
  logic o_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl <= INIT;
      state <= RUN;
      cnt <= '0;
      cfg_done <= 1'b0;
      cfg_out <= INIT[0];
      o_q <= 1'b0;
      O_valid <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      O_valid <= state == RUN && !cfg_start;
      if (state == RUN) o_q <= tbl[I];
      if (cfg_start) begin
        state <= LOAD;
        cnt <= '0;
      end else if (state == LOAD && cfg_valid) begin
        tbl <= {cfg_bit, tbl[N-1:1]};
        cfg_out <= tbl[0];
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= RUN;
          cfg_done <= 1'b1;
        end
      end
    end
  end
  assign cfg_busy = state == LOAD;
  assign O = REG_OUT ? o_q : (state == RUN ? tbl[I] : o_q);
endmodule
